// File: rtl/fma_pkg.sv
// Shared constants and types for the FMA post-adder datapath.
// Defaults describe IEEE-754 single precision.
package fma_pkg;

   localparam int DFLT_MANT = 23;
   localparam int DFLT_EXP  = 8;
   localparam int MAG_W     = 2*DFLT_MANT + 3;
   localparam int BIAS      = (1 << (DFLT_EXP-1)) - 1;
   localparam int EXP_MAX   = (1 << DFLT_EXP) - 1;
   localparam int LZ_W      = $clog2(MAG_W + 1);

   typedef struct packed {
      logic overflow;
      logic underflow;
      logic inexact;
   } fma_flags_t;

endpackage

// File: rtl/fma_norm_round_if.sv
// Handshake and data bundle between the EAC adder, the normalise/round stage and writeback.
// Signal names keep the _i/_o sense as seen from the normalise/round stage.
interface fma_norm_round_if #(
   parameter int PARM_MANT = fma_pkg::DFLT_MANT,
   parameter int PARM_EXP  = fma_pkg::DFLT_EXP
);

   logic                              valid_i;
   logic                              ready_o;
   logic [2*PARM_MANT+1:0]            low_sum_i;
   logic                              low_carry_i;
   logic [2*PARM_MANT+1:0]            low_sum_inv_i;
   logic                              sub_i;
   logic                              sign_i;
   logic signed [PARM_EXP+1:0]        exp_i;
   logic                              valid_o;
   logic                              ready_i;
   logic [PARM_EXP+PARM_MANT:0]       result_o;
   logic                              overflow_o;
   logic                              underflow_o;
   logic                              inexact_o;

   modport master (
      output valid_i, low_sum_i, low_carry_i, low_sum_inv_i, sub_i, sign_i, exp_i, ready_i,
      input  ready_o, valid_o, result_o, overflow_o, underflow_o, inexact_o
   );

   modport slave (
      input  valid_i, low_sum_i, low_carry_i, low_sum_inv_i, sub_i, sign_i, exp_i, ready_i,
      output ready_o, valid_o, result_o, overflow_o, underflow_o, inexact_o
   );

endinterface

// File: rtl/fma_lzc.sv
// Combinational leading-zero counter; an all-zero input yields WIDTH.
module fma_lzc #(
   parameter int WIDTH = fma_pkg::MAG_W
) (
   input  logic [WIDTH-1:0]             data,
   output logic [$clog2(WIDTH+1)-1:0]   count
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   logic found;

   always_comb begin
      count = CNT_W'(WIDTH);
      found = 1'b0;
      for (int i = WIDTH-1; i >= 0; i--) begin
         if (!found && data[i]) begin
            count = CNT_W'(WIDTH-1-i);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fma_norm_round.sv
// FMA post-adder: magnitude/sign select, LZC normalise, RNE round and pack with
// overflow/underflow flush. Two registered stages with an elastic valid/ready handshake.
module fma_norm_round #(
   parameter int PARM_MANT = fma_pkg::DFLT_MANT,
   parameter int PARM_EXP  = fma_pkg::DFLT_EXP
) (
   input  logic            clk_i,
   input  logic            rst_i,
   fma_norm_round_if.slave bus
);

   import fma_pkg::*;

   localparam int MAG_BITS = 2*PARM_MANT + 3;
   localparam int LZ_BITS  = $clog2(MAG_BITS + 1);
   localparam int E_W      = PARM_EXP + 4;
   localparam int RES_W    = PARM_EXP + PARM_MANT + 1;
   localparam int EXP_ALL1 = (1 << PARM_EXP) - 1;

   // Result carries one extra MSB: the mantissa carry-out that bumps the exponent.
   function automatic logic [PARM_MANT:0] round_rne(
      input logic [PARM_MANT-1:0] mant,
      input logic                 guard,
      input logic                 sticky
   );
      logic up;
      up = guard & (sticky | mant[0]);
      return {1'b0, mant} + (PARM_MANT+1)'(up);
   endfunction

   function automatic void pack_result(
      input  logic                  s,
      input  logic signed [E_W-1:0] e,
      input  logic [PARM_MANT-1:0]  mant,
      input  logic                  is_zero,
      input  logic                  lost,
      output logic [RES_W-1:0]      res,
      output fma_flags_t            flg
   );
      res = '0;
      flg = '0;
      if (is_zero) begin
         res = '0;
      end else if (e >= EXP_ALL1) begin
         res           = {s, {PARM_EXP{1'b1}}, {PARM_MANT{1'b0}}};
         flg.overflow  = 1'b1;
         flg.inexact   = 1'b1;
      end else if (e <= 0) begin
         res           = {s, {(RES_W-1){1'b0}}};
         flg.underflow = 1'b1;
         flg.inexact   = 1'b1;
      end else begin
         res           = {s, e[PARM_EXP-1:0], mant};
         flg.inexact   = lost;
      end
   endfunction

   logic                       adv1, adv2;
   logic                       vld_p1, vld_p2;

   logic [MAG_BITS-1:0]        mag_p0;
   logic                       s_p0;
   logic [LZ_BITS-1:0]         lz_p0;

   logic [MAG_BITS-1:0]        mag_p1;
   logic                       s_p1;
   logic signed [PARM_EXP+1:0] exp_p1;
   logic [LZ_BITS-1:0]         lz_p1;

   logic [MAG_BITS-1:0]        norm_p1;
   logic signed [E_W-1:0]      e_p1, e_rnd_p1;
   logic [PARM_MANT-1:0]       mant_p1;
   logic                       guard_p1, sticky_p1;
   logic [PARM_MANT:0]         rnd_p1;
   logic [RES_W-1:0]           res_p1;
   fma_flags_t                 flg_p1;

   logic [RES_W-1:0]           res_p2;
   fma_flags_t                 flg_p2;

   assign adv2        = ~vld_p2 | bus.ready_i;
   assign adv1        = ~vld_p1 | adv2;
   assign bus.ready_o = adv1;

   // ---- stage 0: magnitude / sign select and leading-zero count
   always_comb begin
      mag_p0 = {bus.low_carry_i, bus.low_sum_i};
      s_p0   = bus.sign_i;
      if (bus.sub_i) begin
         if (bus.low_carry_i) begin
            mag_p0 = {1'b0, bus.low_sum_i};
         end else begin
            mag_p0 = {1'b0, bus.low_sum_inv_i};
            s_p0   = ~bus.sign_i;
         end
      end
   end

   fma_lzc #(.WIDTH(MAG_BITS)) u_lzc (
      .data  (mag_p0),
      .count (lz_p0)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)     vld_p1 <= 1'b0;
      else if (adv1) vld_p1 <= bus.valid_i;
   end

   always_ff @(posedge clk_i) begin
      if (adv1 && bus.valid_i) begin
         mag_p1 <= mag_p0;
         s_p1   <= s_p0;
         exp_p1 <= bus.exp_i;
         lz_p1  <= lz_p0;
      end
   end

   // ---- stage 1: normalise, round, pack
   // After normalisation the top bit is the hidden one; it is clear only for a zero magnitude.
   always_comb begin
      norm_p1   = mag_p1 << lz_p1;
      e_p1      = E_W'(exp_p1) - $signed(E_W'(lz_p1));
      mant_p1   = norm_p1[MAG_BITS-2 -: PARM_MANT];
      guard_p1  = norm_p1[MAG_BITS-2-PARM_MANT];
      sticky_p1 = |norm_p1[MAG_BITS-3-PARM_MANT:0];
      rnd_p1    = round_rne(mant_p1, guard_p1, sticky_p1);
      e_rnd_p1  = e_p1 + $signed({{(E_W-1){1'b0}}, rnd_p1[PARM_MANT]});
      res_p1    = '0;
      flg_p1    = '0;
      pack_result(s_p1, e_rnd_p1, rnd_p1[PARM_MANT-1:0], ~norm_p1[MAG_BITS-1],
                  guard_p1 | sticky_p1, res_p1, flg_p1);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)     vld_p2 <= 1'b0;
      else if (adv2) vld_p2 <= vld_p1;
   end

   always_ff @(posedge clk_i) begin
      if (adv2 && vld_p1) begin
         res_p2 <= res_p1;
         flg_p2 <= flg_p1;
      end
   end

   // ---- stage 2: outputs, forced to zero whenever no result is presented
   assign bus.valid_o     = vld_p2;
   assign bus.result_o    = vld_p2 ? res_p2 : '0;
   assign bus.overflow_o  = vld_p2 & flg_p2.overflow;
   assign bus.underflow_o = vld_p2 & flg_p2.underflow;
   assign bus.inexact_o   = vld_p2 & flg_p2.inexact;

endmodule

// File: tb/tb_fma_norm_round.sv
// Directed bench for fma_norm_round: single-precision vectors with hand-computed results,
// latency, backpressure ordering/hold and mid-flight reset.
module tb_fma_norm_round;

   localparam int PM = 23;
   localparam int PE = 8;

   typedef struct packed {
      logic        sub;
      logic        carry;
      logic        sign;
      logic [47:0] sum;
      logic [47:0] sum_inv;
      logic [9:0]  e;
      logic [31:0] res;
      logic [2:0]  flg;
   } beat_t;

   logic  clk = 1'b0;
   logic  rst = 1'b1;
   int    n_checks = 0;
   int    n_errors = 0;
   beat_t vecs [11];

   fma_norm_round_if #(.PARM_MANT(PM), .PARM_EXP(PE)) bus ();

   fma_norm_round #(.PARM_MANT(PM), .PARM_EXP(PE)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic beat_t mk(input logic sub, input logic carry, input logic sign,
                                input logic [47:0] sum, input logic [47:0] sum_inv,
                                input int e, input logic [31:0] res, input logic [2:0] flg);
      beat_t b;
      b.sub = sub; b.carry = carry; b.sign = sign;
      b.sum = sum; b.sum_inv = sum_inv; b.e = 10'(e);
      b.res = res; b.flg = flg;
      return b;
   endfunction

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, want);
      end
   endtask

   task automatic drive(input beat_t b);
      bus.sub_i         = b.sub;
      bus.low_carry_i   = b.carry;
      bus.sign_i        = b.sign;
      bus.low_sum_i     = b.sum;
      bus.low_sum_inv_i = b.sum_inv;
      bus.exp_i         = b.e;
      bus.valid_i       = 1'b1;
   endtask

   function automatic logic [2:0] flags_now();
      return {bus.overflow_o, bus.underflow_o, bus.inexact_o};
   endfunction

   task automatic run_one(input string tag, input beat_t b);
      @(negedge clk);
      drive(b);
      #1 check_val({tag, ".rdy"}, bus.ready_o, 1);
      @(posedge clk);
      #1 bus.valid_i = 1'b0;
      @(negedge clk);
      check_val({tag, ".lat1"}, bus.valid_o, 0);
      @(negedge clk);
      check_val({tag, ".vld"}, bus.valid_o, 1);
      check_val({tag, ".res"}, bus.result_o, b.res);
      check_val({tag, ".flg"}, flags_now(), b.flg);
   endtask

   initial begin
      // {ovf, unf, inx}
      vecs[0]  = mk(0, 0, 0, 48'h4000_0000_0000, 48'h0,              128, 32'h3F00_0000, 3'b000);
      vecs[1]  = mk(0, 1, 0, 48'h0000_0100_0000, 48'h0,              127, 32'h3F80_0000, 3'b001);
      vecs[2]  = mk(0, 1, 0, 48'h0000_0300_0000, 48'h0,              127, 32'h3F80_0002, 3'b001);
      vecs[3]  = mk(1, 0, 0, 48'h1234_5678_9ABC, 48'h4000_0000_0000, 128, 32'hBF00_0000, 3'b000);
      vecs[4]  = mk(1, 0, 0, 48'h1234_5678_9ABC, 48'h0,              128, 32'h0000_0000, 3'b000);
      vecs[5]  = mk(0, 1, 0, 48'h0,              48'h0,              260, 32'h7F80_0000, 3'b101);
      vecs[6]  = mk(0, 1, 0, 48'h0,              48'h0,                0, 32'h0000_0000, 3'b011);
      vecs[7]  = mk(0, 1, 0, 48'hFFFF_FF00_0000, 48'h0,              127, 32'h4000_0000, 3'b001);
      vecs[8]  = mk(1, 1, 1, 48'h0000_0000_0001, 48'hFFFF_FFFF_FFFF, 130, 32'hA900_0000, 3'b000);
      vecs[9]  = mk(0, 0, 0, 48'h4000_0080_0001, 48'h0,              128, 32'h3F00_0001, 3'b001);
      vecs[10] = mk(0, 1, 1, 48'h0,              48'h0,               -5, 32'h8000_0000, 3'b011);

      bus.valid_i = 1'b0; bus.ready_i = 1'b1; bus.sub_i = 1'b0; bus.low_carry_i = 1'b0;
      bus.sign_i = 1'b0; bus.low_sum_i = '0; bus.low_sum_inv_i = '0; bus.exp_i = '0;

      repeat (2) @(negedge clk);
      check_val("rst.valid", bus.valid_o, 0);
      check_val("rst.ready", bus.ready_o, 1);
      check_val("rst.result", bus.result_o, 0);
      check_val("rst.flags", flags_now(), 0);
      rst = 1'b0;

      for (int i = 0; i < 11; i++) run_one($sformatf("v%0d", i), vecs[i]);

      begin : backpressure
         int   in_idx;
         int   out_idx;
         logic acc;
         in_idx  = 0;
         out_idx = 0;
         for (int c = 0; c < 30 && out_idx < 4; c++) begin
            @(negedge clk);
            bus.ready_i = (c >= 3);
            if (in_idx < 4) drive(vecs[in_idx]);
            else            bus.valid_i = 1'b0;
            #1;
            acc = bus.valid_i && bus.ready_o;
            if (c == 2) begin
               check_val("bp.ready_low", bus.ready_o, 0);
               check_val("bp.held_vld", bus.valid_o, 1);
               check_val("bp.held_res2", bus.result_o, vecs[0].res);
            end
            if (c == 3) check_val("bp.held_res3", bus.result_o, vecs[0].res);
            if (bus.valid_o && bus.ready_i) begin
               check_val($sformatf("bp.res%0d", out_idx), bus.result_o, vecs[out_idx].res);
               check_val($sformatf("bp.flg%0d", out_idx), flags_now(), vecs[out_idx].flg);
               out_idx++;
            end
            @(posedge clk);
            if (acc) in_idx++;
         end
         #1 bus.valid_i = 1'b0;
         bus.ready_i = 1'b1;
         check_val("bp.count", out_idx, 4);
      end

      @(negedge clk);
      drive(vecs[0]);
      @(posedge clk);
      #1 drive(vecs[1]);
      @(posedge clk);
      #1 bus.valid_i = 1'b0;
      check_val("rsti.inflight", bus.valid_o, 1);
      #1 rst = 1'b1;
      #1;
      check_val("rsti.valid", bus.valid_o, 0);
      check_val("rsti.result", bus.result_o, 0);
      check_val("rsti.flags", flags_now(), 0);
      check_val("rsti.ready", bus.ready_o, 1);
      @(negedge clk);
      rst = 1'b0;
      run_one("post_rst", vecs[2]);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
